// File: rtl/move_checker.sv
// Connect-four move checker: accepts drops, places pieces and scans for a line of four.
// Define CONNECT4_DIAG_WIN_EN to extend the scan to both diagonals.
module move_checker #(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] current_state,
  input  logic       move_valid,
  input  logic [2:0] move_col,
  output logic [1:0] in_game_status,
  output logic       invalid_column,
  output logic       player_turn,
  output logic       busy,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [1:0] rd_cell
);

  localparam logic [1:0] StatNext  = 2'b00;
  localparam logic [1:0] StatWin   = 2'b01;
  localparam logic [1:0] StatTie   = 2'b10;
  localparam logic [1:0] GsP1Turn  = 2'b01;
  localparam logic [1:0] GsP2Turn  = 2'b10;
  localparam logic [5:0] FullCount = 6'(ROWS * COLS);
  localparam logic [2:0] RowLim    = 3'(ROWS);
  localparam logic [2:0] ColLim    = 3'(COLS);
  localparam logic signed [4:0] RowLimS = 5'(ROWS);
  localparam logic signed [4:0] ColLimS = 5'(COLS);

`ifdef CONNECT4_DIAG_WIN_EN
  localparam logic [1:0] LastAxis = 2'd3;
`else
  localparam logic [1:0] LastAxis = 2'd1;
`endif

  typedef enum logic [1:0] {StIdle, StPlace, StScan, StReport} fsm_e;

  fsm_e state_q, state_d;

  logic [1:0] board_q  [ROWS][COLS];
  logic [2:0] height_q [COLS];
  logic [5:0] count_q;

  // Placed cell and the colour latched at acceptance.
  logic [2:0] row_q, col_q;
  logic [1:0] colour_q;

  logic [1:0] axis_q, axis_d;
  logic       neg_q, neg_d;
  logic [1:0] step_q, step_d;
  logic [2:0] run_q, run_d;
  logic       win_q, win_d;

  logic [1:0] status_q;
  logic       invalid_q;
  logic       turn_q;

  logic       req_ok;
  logic       col_legal;
  logic [2:0] req_height;

  assign req_ok = move_valid && (state_q == StIdle) && (status_q == StatNext) &&
                  ((current_state == GsP1Turn) || (current_state == GsP2Turn));

  // An out-of-range column is treated as a full one.
  assign req_height = (move_col < ColLim) ? height_q[move_col] : RowLim;
  assign col_legal  = (req_height < RowLim);

  logic signed [4:0] d_row, d_col, step_s, p_row, p_col;
  logic              p_in, p_match;

  always_comb begin
    d_row = 5'sd0;
    d_col = 5'sd1;
    case (axis_q)
      2'd0:    begin d_row = 5'sd0; d_col = 5'sd1;  end
      2'd1:    begin d_row = 5'sd1; d_col = 5'sd0;  end
      2'd2:    begin d_row = 5'sd1; d_col = 5'sd1;  end
      default: begin d_row = 5'sd1; d_col = -5'sd1; end
    endcase
    step_s  = neg_q ? -$signed({3'b000, step_q}) : $signed({3'b000, step_q});
    p_row   = $signed({2'b00, row_q}) + d_row * step_s;
    p_col   = $signed({2'b00, col_q}) + d_col * step_s;
    p_in    = (p_row >= 5'sd0) && (p_row < RowLimS) && (p_col >= 5'sd0) && (p_col < ColLimS);
    p_match = p_in && (board_q[p_row[2:0]][p_col[2:0]] == colour_q);
  end

  always_comb begin
    state_d = state_q;
    axis_d  = axis_q;
    neg_d   = neg_q;
    step_d  = step_q;
    run_d   = run_q;
    win_d   = win_q;
    case (state_q)
      StIdle: begin
        if (req_ok && col_legal) begin
          state_d = StPlace;
          axis_d  = 2'd0;
          neg_d   = 1'b0;
          step_d  = 2'd1;
          run_d   = 3'd1;
          win_d   = 1'b0;
        end
      end
      StPlace: state_d = StScan;
      StScan: begin
        if (p_match && (run_q == 3'd3)) begin
          win_d   = 1'b1;
          state_d = StReport;
        end else if (p_match && (step_q != 2'd3)) begin
          step_d = step_q + 2'd1;
          run_d  = run_q + 3'd1;
        end else begin
          // Direction finished: flip to the - side, then advance to the next axis.
          if (p_match) run_d = run_q + 3'd1;
          step_d = 2'd1;
          if (!neg_q) begin
            neg_d = 1'b1;
          end else if (axis_q == LastAxis) begin
            state_d = StReport;
          end else begin
            axis_d = axis_q + 2'd1;
            neg_d  = 1'b0;
            run_d  = 3'd1;
          end
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      axis_q  <= 2'd0;
      neg_q   <= 1'b0;
      step_q  <= 2'd1;
      run_q   <= 3'd1;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      axis_q  <= axis_d;
      neg_q   <= neg_d;
      step_q  <= step_d;
      run_q   <= run_d;
      win_q   <= win_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          board_q[3'(r)][3'(c)] <= 2'b00;
        end
      end
      for (int unsigned c = 0; c < COLS; c++) begin
        height_q[3'(c)] <= 3'd0;
      end
      count_q   <= 6'd0;
      row_q     <= 3'd0;
      col_q     <= 3'd0;
      colour_q  <= 2'b00;
      status_q  <= StatNext;
      invalid_q <= 1'b0;
      turn_q    <= 1'b0;
    end else begin
      if (req_ok) begin
        if (col_legal) begin
          row_q     <= req_height;
          col_q     <= move_col;
          colour_q  <= current_state;
          invalid_q <= 1'b0;
        end else begin
          invalid_q <= 1'b1;
        end
      end
      if (state_q == StPlace) begin
        board_q[row_q][col_q] <= colour_q;
        height_q[col_q]       <= height_q[col_q] + 3'd1;
        count_q               <= count_q + 6'd1;
      end
      if (state_q == StReport) begin
        if (win_q) begin
          status_q <= StatWin;
        end else if (count_q == FullCount) begin
          status_q <= StatTie;
        end else begin
          turn_q <= ~turn_q;
        end
      end
    end
  end

  assign rd_cell = ((rd_row < RowLim) && (rd_col < ColLim)) ? board_q[rd_row][rd_col] : 2'b00;

  assign in_game_status = status_q;
  assign invalid_column = invalid_q;
  assign player_turn    = turn_q;
  assign busy           = (state_q != StIdle);

endmodule
